// File: rtl/mmv_ps_pkg.sv
// Shared definitions for the MemoryMapped <-> PacketStream encoder/decoder pair.
package mmv_ps_pkg;

  // Header bit positions
  localparam int unsigned PACK_TYPE_BIT = 0;
  localparam int unsigned WREQ_TYPE_BIT = 1;
  localparam int unsigned RREQ_TYPE_BIT = 2;

  // Packet type values carried in PACK_TYPE_BIT
  localparam logic REQ_PACK_TYPE = 1'b0;
  localparam logic RES_PACK_TYPE = 1'b1;

  // Widest header the builder can produce; users take the low WIDTH bits
  localparam int unsigned HDR_MAX_W = 64;

  // Decoder FSM states
  typedef enum logic [3:0] {
    StHdr,
    StAddr,
    StWdat,
    StWr,
    StRd,
    StRval,
    StResHdr,
    StResDat,
    StFlush
  } dec_state_e;

  // Read-response header: response type with the read bit set, all else zero
  function automatic logic [HDR_MAX_W-1:0] build_res_hdr();
    logic [HDR_MAX_W-1:0] hdr;
    hdr                = '0;
    hdr[PACK_TYPE_BIT] = RES_PACK_TYPE;
    hdr[RREQ_TYPE_BIT] = 1'b1;
    return hdr;
  endfunction

endpackage

// File: rtl/ps_twinreg_buffer.sv
// Two-register stream buffer: one-cycle latency, all outputs registered,
// no combinational path from o_rdy to any output.
module ps_twinreg_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_val,
  input  logic             i_eop,
  output logic             i_rdy,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_val,
  output logic             o_eop,
  input  logic             o_rdy
);

  logic [WIDTH-1:0] dat_q, dat_d, skd_dat_q, skd_dat_d;
  logic             val_q, val_d, eop_q, eop_d;
  logic             skd_val_q, skd_val_d, skd_eop_q, skd_eop_d;
  logic             push;

  // Output register refills from the skid register first, else from the input
  always_comb begin
    dat_d     = dat_q;
    val_d     = val_q;
    eop_d     = eop_q;
    skd_dat_d = skd_dat_q;
    skd_val_d = skd_val_q;
    skd_eop_d = skd_eop_q;
    push      = i_val & ~skd_val_q;
    if (!val_q || o_rdy) begin
      if (skd_val_q) begin
        val_d     = 1'b1;
        dat_d     = skd_dat_q;
        eop_d     = skd_eop_q;
        skd_val_d = 1'b0;
      end else begin
        val_d = push;
        if (push) begin
          dat_d = i_dat;
          eop_d = i_eop;
        end
      end
    end else if (push) begin
      skd_val_d = 1'b1;
      skd_dat_d = i_dat;
      skd_eop_d = i_eop;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q     <= '0;
      val_q     <= 1'b0;
      eop_q     <= 1'b0;
      skd_dat_q <= '0;
      skd_val_q <= 1'b0;
      skd_eop_q <= 1'b0;
    end else begin
      dat_q     <= dat_d;
      val_q     <= val_d;
      eop_q     <= eop_d;
      skd_dat_q <= skd_dat_d;
      skd_val_q <= skd_val_d;
      skd_eop_q <= skd_eop_d;
    end
  end

  assign i_rdy = ~skd_val_q;
  assign o_dat = dat_q;
  assign o_val = val_q;
  assign o_eop = eop_q & val_q;

endmodule

// File: rtl/ps_to_mmv_dec.sv
// PacketStream request decoder: replays each request packet as one MM
// transaction and returns read data as a response packet.
module ps_to_mmv_dec
  import mmv_ps_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_val,
  input  logic             i_eop,
  output logic             i_rdy,
  output logic [WIDTH-1:0] m_addr,
  output logic             m_wreq,
  output logic [WIDTH-1:0] m_wdat,
  output logic             m_rreq,
  input  logic [WIDTH-1:0] m_rdat,
  input  logic             m_rval,
  input  logic             m_busy,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_val,
  output logic             o_eop,
  input  logic             o_rdy
);

  localparam logic [WIDTH-1:0] ResHdr = WIDTH'(build_res_hdr());

  dec_state_e       state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic             flush_q, flush_d;   // packet still has words after the last one used
  logic [WIDTH-1:0] rdat_q, rdat_d;
  logic             i_rdy_q, i_rdy_d;
  logic             m_wreq_q, m_wreq_d, m_rreq_q, m_rreq_d;
  logic [WIDTH-1:0] m_addr_q, m_addr_d, m_wdat_q, m_wdat_d;

  logic             acc, hdr_wr, hdr_rd;
  logic [WIDTH-1:0] buf_dat;
  logic             buf_val, buf_eop, buf_rdy;

  assign acc    = i_val & i_rdy_q;
  // Write wins over read when both bits are set
  assign hdr_wr = (i_dat[PACK_TYPE_BIT] == REQ_PACK_TYPE) & i_dat[WREQ_TYPE_BIT];
  assign hdr_rd = (i_dat[PACK_TYPE_BIT] == REQ_PACK_TYPE) & ~i_dat[WREQ_TYPE_BIT]
                & i_dat[RREQ_TYPE_BIT];

  // Next-state and registered-output logic of the request FSM
  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    flush_d  = flush_q;
    rdat_d   = rdat_q;
    m_wreq_d = m_wreq_q;
    m_rreq_d = m_rreq_q;
    m_addr_d = m_addr_q;
    m_wdat_d = m_wdat_q;
    buf_val  = 1'b0;
    buf_dat  = rdat_q;
    buf_eop  = 1'b0;
    unique case (state_q)
      StHdr: begin
        if (acc) begin
          if (hdr_wr || hdr_rd) begin
            // A lone valid header carries no address: drop it
            if (!i_eop) begin
              state_d = StAddr;
              is_wr_d = hdr_wr;
            end
          end else if (!i_eop) begin
            state_d = StFlush;
          end
        end
      end
      StAddr: begin
        if (acc) begin
          m_addr_d = i_dat;
          if (is_wr_q) begin
            state_d = i_eop ? StHdr : StWdat;
          end else begin
            m_rreq_d = 1'b1;
            flush_d  = ~i_eop;
            state_d  = StRd;
          end
        end
      end
      StWdat: begin
        if (acc) begin
          m_wdat_d = i_dat;
          m_wreq_d = 1'b1;
          flush_d  = ~i_eop;
          state_d  = StWr;
        end
      end
      StWr: begin
        if (!m_busy) begin
          m_wreq_d = 1'b0;
          state_d  = flush_q ? StFlush : StHdr;
        end
      end
      StRd: begin
        if (!m_busy) begin
          m_rreq_d = 1'b0;
          state_d  = StRval;
        end
      end
      StRval: begin
        if (m_rval) begin
          rdat_d  = m_rdat;
          state_d = StResHdr;
        end
      end
      StResHdr: begin
        buf_val = 1'b1;
        buf_dat = ResHdr;
        if (buf_rdy) state_d = StResDat;
      end
      StResDat: begin
        buf_val = 1'b1;
        buf_eop = 1'b1;
        if (buf_rdy) state_d = flush_q ? StFlush : StHdr;
      end
      StFlush: begin
        if (acc && i_eop) state_d = StHdr;
      end
      default: state_d = StHdr;
    endcase
    i_rdy_d = (state_d == StHdr) || (state_d == StAddr) || (state_d == StWdat) ||
              (state_d == StFlush);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StHdr;
      is_wr_q  <= 1'b0;
      flush_q  <= 1'b0;
      rdat_q   <= '0;
      i_rdy_q  <= 1'b0;
      m_wreq_q <= 1'b0;
      m_rreq_q <= 1'b0;
      m_addr_q <= '0;
      m_wdat_q <= '0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      flush_q  <= flush_d;
      rdat_q   <= rdat_d;
      i_rdy_q  <= i_rdy_d;
      m_wreq_q <= m_wreq_d;
      m_rreq_q <= m_rreq_d;
      m_addr_q <= m_addr_d;
      m_wdat_q <= m_wdat_d;
    end
  end

  assign i_rdy  = i_rdy_q;
  assign m_wreq = m_wreq_q;
  assign m_rreq = m_rreq_q;
  assign m_addr = m_addr_q;
  assign m_wdat = m_wdat_q;

  ps_twinreg_buffer #(
    .WIDTH (WIDTH)
  ) u_res_buf (
    .clk   (clk),
    .rst   (rst),
    .i_dat (buf_dat),
    .i_val (buf_val),
    .i_eop (buf_eop),
    .i_rdy (buf_rdy),
    .o_dat (o_dat),
    .o_val (o_val),
    .o_eop (o_eop),
    .o_rdy (o_rdy)
  );

endmodule

// File: tb/tb_ps_to_mmv_dec.sv
// Self-checking bench for ps_to_mmv_dec: directed vector table, multi-cycle
// corner sequences and a randomized run against a packet-level model.
module tb_ps_to_mmv_dec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_dat = 8'h00;
  logic       i_val = 1'b0;
  logic       i_eop = 1'b0;
  logic       i_rdy;
  logic [7:0] m_addr, m_wdat;
  logic       m_wreq, m_rreq;
  logic [7:0] m_rdat = 8'h00;
  logic       m_rval = 1'b0;
  logic       m_busy = 1'b0;
  logic [7:0] o_dat;
  logic       o_val, o_eop;
  logic       o_rdy = 1'b1;

  always #5 clk = ~clk;

  ps_to_mmv_dec #(
    .WIDTH (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_dat  (i_dat),
    .i_val  (i_val),
    .i_eop  (i_eop),
    .i_rdy  (i_rdy),
    .m_addr (m_addr),
    .m_wreq (m_wreq),
    .m_wdat (m_wdat),
    .m_rreq (m_rreq),
    .m_rdat (m_rdat),
    .m_rval (m_rval),
    .m_busy (m_busy),
    .o_dat  (o_dat),
    .o_val  (o_val),
    .o_eop  (o_eop),
    .o_rdy  (o_rdy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mem [256];

  // Observed traffic, written only by the monitor
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [8:0]  out_q[$];
  int in_acc = 0, wreq_cyc = 0, rreq_cyc = 0, rd_acc_cnt = 0, cyc = 0;
  int rval_cyc = 0, rise_cyc = 0, stall_viol = 0;
  logic       prev_stall = 1'b0, prev_oval = 1'b0;
  logic [8:0] prev_out = 9'h000;

  // Knobs, written only by the main sequence
  logic busy_hold = 1'b0, rand_busy = 1'b0, rand_ordy = 1'b0, ordy_low = 1'b0;
  logic rand_lat = 1'b0;
  int   fix_lat  = 2;
  logic hung     = 1'b0;

  // Expected traffic from the packet model
  logic [15:0] ew[$];
  logic [7:0]  er[$];
  logic [8:0]  eo[$];

  // Monitor: samples every handshake on the falling edge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
      prev_oval  = 1'b0;
    end else begin
      cyc++;
      if (i_val && i_rdy) in_acc++;
      if (m_wreq) begin
        wreq_cyc++;
        if (!m_busy) wr_q.push_back({m_addr, m_wdat});
      end
      if (m_rreq) begin
        rreq_cyc++;
        if (!m_busy) begin
          rd_q.push_back(m_addr);
          rd_acc_cnt++;
        end
      end
      if (m_rval) rval_cyc = cyc;
      if (o_val && !prev_oval) rise_cyc = cyc;
      if (prev_stall && (!o_val || {o_eop, o_dat} != prev_out)) stall_viol++;
      if (o_val && o_rdy) out_q.push_back({o_eop, o_dat});
      prev_stall = o_val && !o_rdy;
      prev_out   = {o_eop, o_dat};
      prev_oval  = o_val;
    end
  end

  // MM slave and response sink: drives busy, read data and o_rdy
  int         rd_served = 0, wait_cnt = 0;
  logic [7:0] pend_addr = 8'h00;
  initial forever begin
    @(posedge clk);
    #2;
    m_busy = busy_hold || (rand_busy && $urandom_range(0, 2) == 0);
    o_rdy  = !ordy_low && (!rand_ordy || $urandom_range(0, 3) != 0);
    m_rval = 1'b0;
    if (rst) begin
      wait_cnt  = 0;
      rd_served = rd_acc_cnt;
    end else begin
      if (rd_served != rd_acc_cnt) begin
        wait_cnt  = rand_lat ? int'($urandom_range(1, 4)) : fix_lat;
        pend_addr = rd_q[rd_served];
        rd_served++;
      end
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          m_rval = 1'b1;
          m_rdat = mem[pend_addr];
        end
      end else if (rand_busy && $urandom_range(0, 4) == 0) begin
        // Stray strobe while no read is outstanding
        m_rval = 1'b1;
        m_rdat = 8'($urandom);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is taken
  task automatic send_word(input logic [7:0] d, input logic e, input int gap);
    int t;
    logic done;
    t    = 0;
    done = 1'b0;
    if (hung) return;
    wait_cycles(gap);
    i_dat = d;
    i_eop = e;
    i_val = 1'b1;
    while (!done && t < 400) begin
      @(negedge clk);
      if (i_rdy) done = 1'b1;
      else t++;
    end
    @(posedge clk);
    #1;
    i_val = 1'b0;
    if (!done) begin
      hung = 1'b1;
      check("send_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic send_pkt(input logic [7:0] w[$], input int gap_max);
    for (int k = 0; k < w.size(); k++)
      send_word(w[k], k == w.size() - 1, $urandom_range(0, gap_max));
  endtask

  // Packet-level reference: what a request packet must cause
  task automatic model_pkt(input logic [7:0] w[$]);
    logic [7:0] h;
    h = w[0];
    if (h[0]) return;
    if (h[1]) begin
      if (w.size() >= 3) ew.push_back({w[1], w[2]});
    end else if (h[2]) begin
      if (w.size() >= 2) begin
        er.push_back(w[1]);
        eo.push_back({1'b0, 8'h05});
        eo.push_back({1'b1, mem[w[1]]});
      end
    end
  endtask

  typedef struct {
    logic [7:0]  w0, w1, w2;
    int          len;
    int          nwr;
    logic [15:0] wr;
    int          nrd;
    logic [7:0]  ra;
  } vec_t;

  vec_t        tbl[8];
  logic [7:0]  pkt[$];
  int          wb, rb, ob, ib, wcb, rcb, nwords, early;
  logic        seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h02, 8'h34, 8'hA5, 3, 1, 16'h34A5, 0, 8'h00};
    tbl[1] = '{8'h04, 8'h10, 8'h00, 2, 0, 16'h0000, 1, 8'h10};
    tbl[2] = '{8'h01, 8'h11, 8'h22, 3, 0, 16'h0000, 0, 8'h00};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 1, 0, 16'h0000, 0, 8'h00};
    tbl[4] = '{8'h06, 8'h20, 8'h77, 3, 1, 16'h2077, 0, 8'h00};
    tbl[5] = '{8'h02, 8'h20, 8'h00, 2, 0, 16'h0000, 0, 8'h00};
    tbl[6] = '{8'h04, 8'h08, 8'hFF, 3, 0, 16'h0000, 1, 8'h08};
    tbl[7] = '{8'h08, 8'h01, 8'h00, 2, 0, 16'h0000, 0, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h5C;

    // Reset values
    @(negedge clk);
    check("rst_i_rdy", {31'd0, i_rdy}, 32'd0);
    check("rst_m_wreq", {31'd0, m_wreq}, 32'd0);
    check("rst_m_rreq", {31'd0, m_rreq}, 32'd0);
    check("rst_m_addr", {24'd0, m_addr}, 32'd0);
    check("rst_m_wdat", {24'd0, m_wdat}, 32'd0);
    check("rst_o_val", {31'd0, o_val}, 32'd0);
    check("rst_o_eop", {31'd0, o_eop}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(1);
    check("post_rst_i_rdy", {31'd0, i_rdy}, 32'd1);

    // Directed vector table, busy low, o_rdy high
    for (int v = 0; v < 8; v++) begin
      wb = wr_q.size(); rb = rd_q.size(); ob = out_q.size();
      ib = in_acc; wcb = wreq_cyc;
      pkt.delete();
      pkt.push_back(tbl[v].w0);
      if (tbl[v].len > 1) pkt.push_back(tbl[v].w1);
      if (tbl[v].len > 2) pkt.push_back(tbl[v].w2);
      send_pkt(pkt, 0);
      wait_cycles(20);
      check($sformatf("v%0d_nwr", v), wr_q.size() - wb, tbl[v].nwr);
      check($sformatf("v%0d_wreq_cycles", v), wreq_cyc - wcb, tbl[v].nwr);
      if (tbl[v].nwr > 0 && wr_q.size() > wb)
        check($sformatf("v%0d_wr", v), {16'd0, wr_q[wb]}, {16'd0, tbl[v].wr});
      check($sformatf("v%0d_nrd", v), rd_q.size() - rb, tbl[v].nrd);
      check($sformatf("v%0d_nout", v), out_q.size() - ob, 2 * tbl[v].nrd);
      if (tbl[v].nrd > 0 && out_q.size() >= ob + 2) begin
        check($sformatf("v%0d_raddr", v), {24'd0, rd_q[rb]}, {24'd0, tbl[v].ra});
        check($sformatf("v%0d_res_hdr", v), {23'd0, out_q[ob]}, 32'h005);
        check($sformatf("v%0d_res_dat", v), {23'd0, out_q[ob + 1]},
              {23'd0, 1'b1, mem[tbl[v].ra]});
      end
      check($sformatf("v%0d_words_taken", v), in_acc - ib, tbl[v].len);
    end

    // Read with busy held 3 cycles and read latency 4
    fix_lat = 4;
    busy_hold = 1'b1;
    rb = rd_q.size(); ob = out_q.size(); rcb = rreq_cyc;
    pkt.delete(); pkt.push_back(8'h04); pkt.push_back(8'h10);
    send_pkt(pkt, 0);
    wait_cycles(3);
    busy_hold = 1'b0;
    early = 0;
    seen  = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (o_val && o_eop) begin
        seen = 1'b1;
        check("lat_rdy_after_queue", {31'd0, i_rdy}, 32'd1);
      end else if (i_rdy) begin
        early++;
      end
    end
    @(posedge clk);
    #1;
    check("lat_resp_seen", {31'd0, seen}, 32'd1);
    check("lat_rdy_low_until_queued", early, 0);
    wait_cycles(3);
    check("lat_rreq_cycles", rreq_cyc - rcb, 4);
    check("lat_nrd", rd_q.size() - rb, 1);
    if (rd_q.size() > rb) check("lat_raddr", {24'd0, rd_q[rb]}, 32'h10);
    check("lat_hdr_delay", rise_cyc - rval_cyc, 2);
    check("lat_nout", out_q.size() - ob, 2);
    if (out_q.size() >= ob + 2) begin
      check("lat_res_hdr", {23'd0, out_q[ob]}, 32'h005);
      check("lat_res_dat", {23'd0, out_q[ob + 1]}, 32'h15C);
    end
    fix_lat = 2;

    // Response stalled by o_rdy low for 10+ cycles
    ordy_low = 1'b1;
    ob = out_q.size(); wb = wr_q.size();
    pkt.delete(); pkt.push_back(8'h04); pkt.push_back(8'h20);
    send_pkt(pkt, 0);
    wait_cycles(12);
    check("stall_no_out", out_q.size() - ob, 0);
    check("stall_o_val", {31'd0, o_val}, 32'd1);
    check("stall_o_dat", {24'd0, o_dat}, 32'h05);
    ordy_low = 1'b0;
    wait_cycles(6);
    check("stall_nout", out_q.size() - ob, 2);
    if (out_q.size() >= ob + 2) begin
      check("stall_res_hdr", {23'd0, out_q[ob]}, 32'h005);
      check("stall_res_dat", {23'd0, out_q[ob + 1]}, {23'd0, 1'b1, mem[8'h20]});
    end
    pkt.delete(); pkt.push_back(8'h02); pkt.push_back(8'h44); pkt.push_back(8'h99);
    send_pkt(pkt, 0);
    wait_cycles(6);
    check("stall_next_nwr", wr_q.size() - wb, 1);
    if (wr_q.size() > wb) check("stall_next_wr", {16'd0, wr_q[wb]}, 32'h4499);

    // Reset while a read request is pending
    busy_hold = 1'b1;
    pkt.delete(); pkt.push_back(8'h04); pkt.push_back(8'h30);
    send_pkt(pkt, 0);
    wait_cycles(2);
    check("rst_pre_rreq", {31'd0, m_rreq}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_rreq", {31'd0, m_rreq}, 32'd0);
    check("rst_async_o_val", {31'd0, o_val}, 32'd0);
    check("rst_async_i_rdy", {31'd0, i_rdy}, 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    busy_hold = 1'b0;
    wait_cycles(1);
    rb = rd_q.size(); ob = out_q.size();
    pkt.delete(); pkt.push_back(8'h04); pkt.push_back(8'h31);
    send_pkt(pkt, 0);
    wait_cycles(15);
    check("rst_after_nrd", rd_q.size() - rb, 1);
    check("rst_after_nout", out_q.size() - ob, 2);
    if (out_q.size() >= ob + 2) begin
      check("rst_after_hdr", {23'd0, out_q[ob]}, 32'h005);
      check("rst_after_dat", {23'd0, out_q[ob + 1]}, {23'd0, 1'b1, mem[8'h31]});
    end

    // Randomized packets against the packet model
    rand_busy = 1'b1; rand_ordy = 1'b1; rand_lat = 1'b1;
    ew.delete(); er.delete(); eo.delete();
    wb = wr_q.size(); rb = rd_q.size(); ob = out_q.size(); ib = in_acc;
    nwords = 0;
    for (int p = 0; p < 60; p++) begin
      logic [7:0] h;
      int         len;
      h = 8'($urandom);
      case ($urandom_range(0, 5))
        0: begin h[0] = 1'b0; h[1] = 1'b1; len = $urandom_range(3, 5); end
        1: begin h[2:0] = 3'b100; len = $urandom_range(2, 3); end
        2: begin h[0] = 1'b1; len = $urandom_range(1, 3); end
        3: begin h[2:0] = 3'b000; len = $urandom_range(1, 3); end
        4: begin h[0] = 1'b0; h[1] = 1'b1; len = $urandom_range(1, 2); end
        default: begin h[2:0] = 3'b100; len = 1; end
      endcase
      pkt.delete();
      pkt.push_back(h);
      for (int k = 1; k < len; k++) pkt.push_back(8'($urandom));
      nwords += len;
      model_pkt(pkt);
      send_pkt(pkt, 2);
    end
    for (int k = 0; k < 3000 && (out_q.size() - ob) < eo.size(); k++) wait_cycles(1);
    wait_cycles(20);
    check("rnd_words_taken", in_acc - ib, nwords);
    check("rnd_nwr", wr_q.size() - wb, ew.size());
    check("rnd_nrd", rd_q.size() - rb, er.size());
    check("rnd_nout", out_q.size() - ob, eo.size());
    for (int k = 0; k < ew.size() && wb + k < wr_q.size(); k++)
      check($sformatf("rnd_wr%0d", k), {16'd0, wr_q[wb + k]}, {16'd0, ew[k]});
    for (int k = 0; k < er.size() && rb + k < rd_q.size(); k++)
      check($sformatf("rnd_rd%0d", k), {24'd0, rd_q[rb + k]}, {24'd0, er[k]});
    for (int k = 0; k < eo.size() && ob + k < out_q.size(); k++)
      check($sformatf("rnd_out%0d", k), {23'd0, out_q[ob + k]}, {23'd0, eo[k]});
    check("out_stable_under_stall", stall_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps_to_mmv_dec.md
Name: ps_to_mmv_dec

Overview:
- Far-end counterpart of the MemoryMapped-to-PacketStream encoder.
- Consumes request packets from the inbound stream and replays each one as a single MemoryMapped master transaction with variable read latency.
- Returns read data to the encoder as response packets on the outbound stream.
- Sits on the remote side of the packet link and drives the local register bus.

Parameters:
- WIDTH, 8, address/data/stream width; must be ≥ 3.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_dat  in  WIDTH  request stream data
- i_val  in  1  request stream valid
- i_eop  in  1  request stream end of packet
- i_rdy  out  1  request stream ready
- m_addr  out  WIDTH  MM master address
- m_wreq  out  1  MM write request
- m_wdat  out  WIDTH  MM write data
- m_rreq  out  1  MM read request
- m_rdat  in  WIDTH  MM read data
- m_rval  in  1  MM read data valid
- m_busy  in  1  MM slave busy (request held while high)
- o_dat  out  WIDTH  response stream data
- o_val  out  1  response stream valid
- o_eop  out  1  response stream end of packet
- o_rdy  in  1  response stream ready

Behaviour:
- One clock. Reset is asynchronous and active-high; clock port clk, reset port rst.
- Header bit positions:
  - bit0: packet type (0 = request, 1 = response)
  - bit1: write request
  - bit2: read request
- Request packet formats:
  - Write: header, addr, wdat(eop).
  - Read: header, addr(eop).
- Header decode:
  - bit0 = 1 → malformed, drop.
  - bit1 = 1 → write; bit2 is ignored.
  - Else bit2 = 1 → read.
  - Else → malformed, drop.
- Response packet: header 0x...05 (bit0 = 1, bit2 = 1, other bits 0), then the read word with eop.
- FSM states and transitions:
  - st_hdr: i_rdy = 1. A valid header moves to st_addr. A malformed header without eop moves to st_flush; with eop, stay in st_hdr.
  - st_addr: i_rdy = 1. Capture addr. Write → st_wdat. Read → st_rd. Early eop on a write packet → drop the packet, no MM access, → st_hdr.
  - st_wdat: i_rdy = 1. Capture wdat, then → st_wr.
  - st_wr: m_wreq = 1 with m_addr/m_wdat held stable until a cycle with m_busy = 0. Then → st_hdr, or → st_flush if the last accepted word lacked eop.
  - st_rd: m_rreq = 1 held until m_busy = 0, then → st_rval.
  - st_rval: wait for m_rval; capture m_rdat, then → st_res_hdr.
  - st_res_hdr: push the header into the output buffer when the buffer is ready, then → st_res_dat.
  - st_res_dat: push the captured data with eop when the buffer is ready. Then → st_hdr, or → st_flush if the read packet lacked eop.
  - st_flush: i_rdy = 1; discard words up to and including eop, then → st_hdr.
- i_rdy = 0 in st_wr, st_rd, st_rval, st_res_hdr and st_res_dat.
- Only one MM transaction is outstanding; no new request word is accepted until the read response is queued.
- m_rval is ignored outside st_rval. m_rval can arrive no earlier than the cycle after the accepting cycle (m_rreq with m_busy = 0).
- MM outputs are registered:
  - m_wreq/m_rreq rise in the cycle after the final request word is accepted.
  - m_wreq/m_rreq drop in the cycle after acceptance.
- Output buffer: ps_twinreg_buffer, one-cycle latency, no combinational path from o_rdy to o_*.
- Latency: m_rval at cycle M → o_val (header) at M+2, data at M+3 if o_rdy = 1.
- Reset values:
  - FSM = st_hdr
  - i_rdy = 0 while rst is asserted, 1 after release
  - m_wreq = 0, m_rreq = 0
  - m_addr = 0, m_wdat = 0
  - o_val = 0, o_eop = 0
- Reset mid-operation aborts any pending MM request immediately; a partial response packet is discarded.

Decomposition:
- Shared package mmv_ps_pkg holds:
  - PACK_TYPE_BIT, WREQ_TYPE_BIT, RREQ_TYPE_BIT
  - REQ_PACK_TYPE, RES_PACK_TYPE
  - response header builder function
- Both encoder and decoder import mmv_ps_pkg.
- Sub-module: existing ps_twinreg_buffer on the response path; no new sub-module.

Test Plan:
- Write packet 0x02, 0x34, 0xA5(eop), m_busy = 0 → exactly one m_wreq pulse with m_addr = 0x34, m_wdat = 0xA5; no outbound traffic.
- Read packet 0x04, 0x10(eop); m_busy high for 3 cycles; m_rval with 0x5C four cycles later:
  - m_rreq held 4 cycles with m_addr = 0x10;
  - outbound 0x05, 0x5C(eop);
  - i_rdy = 0 until the response is queued.
- Read response with o_rdy = 0 for 10 cycles → o_dat/o_val stable, no data lost; packet completes once o_rdy = 1; the next request is accepted only afterwards.
- Malformed packets are flushed and then a valid write is served:
  - Header 0x01 with 2 trailing words, then header 0x00(eop) → no MM access, all words consumed.
  - A following valid write is then served.
- Header 0x06 (both bits), 0x20, 0x77(eop) → treated as write: m_wreq, addr 0x20, data 0x77; no m_rreq.
- Short and long packets:
  - Write 0x02, 0x20(eop) → dropped, no MM access.
  - Read 0x04, 0x08, 0xFF(eop) → read of 0x08 served; extra word flushed.
- rst asserted while m_rreq is high → m_rreq = 0 asynchronously, o_val = 0; after release a new read completes normally.
